alu_cmd_issuer: RTL
===================

# alu_cmd_issuer

Upstream command stage for the 8-bit ALU core. Accepts operand/operation commands over a valid/ready handshake and buffers them in a small FIFO. Replays each command to the ALU as a fixed load → persist → reset control sequence on `on`, `in_sel`, `num1`, `num2` and `out_sel`. Removes the hand-timed stimulus the ALU otherwise needs and lets producers issue commands back-to-back.

## Interface
- `DATA_W`, 8: operand width.
- `OPSEL_W`, 7: width of the one-hot operation select.
- `DEPTH`, 4: FIFO entries; must be a power of two, minimum 2.
- `HOLD_CYCLES`, 2: persist cycles per command; minimum 1.

- `clk`  input  1  rising-edge clock; only clock in the block.
- `rst`  input  1  reset, asynchronous and active-low.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  block can accept a command.
- `cmd_a`  input  DATA_W  first operand.
- `cmd_b`  input  DATA_W  second operand.
- `cmd_op`  input  OPSEL_W  one-hot operation select.
- `on`  output  1  ALU enable.
- `in_sel`  output  3  ALU control: bit2 persist, bit1 load, bit0 reset.
- `num1`  output  DATA_W  ALU operand 1.
- `num2`  output  DATA_W  ALU operand 2.
- `out_sel`  output  OPSEL_W  ALU operation select.
- `busy`  output  1  FIFO non-empty or FSM not in IDLE.
- `err_op`  output  1  one-cycle pulse: a command was dropped for an illegal `cmd_op`.
- `issued_count`  output  8  number of LOAD phases issued; wraps modulo 256.

## Operation
- Handshake:
  - A transfer occurs on a rising edge where `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`, and is forced to 0 while `rst` is low.
  - A producer may hold `cmd_valid` with changing data; only the transfer-edge values are used.
- Op check:
  - A transferred `cmd_op` that is zero, or has more than one bit set, is consumed but not stored.
  - `err_op` is 1 for exactly the cycle after that edge.
  - FIFO, FSM and `issued_count` are unaffected.
- FIFO:
  - DEPTH entries of {a, b, op}.
  - The head entry stays in the FIFO for the whole time it executes.
  - It is popped on the edge that leaves CLEAR.
  - A push and a pop on the same edge are both performed; occupancy is unchanged.
- FSM states and outputs (all outputs registered):
  - IDLE: `on`=0, `in_sel`=000, `num1`/`num2`/`out_sel` keep their last values.
  - LOAD: `on`=1, `in_sel`=010, `num1`/`num2`/`out_sel` = FIFO head.
  - HOLD: `on`=1, `in_sel`=100, data outputs unchanged.
  - CLEAR: `on`=1, `in_sel`=001, data outputs unchanged.
- FSM transitions:
  - IDLE→LOAD when the FIFO is non-empty.
  - LOAD→HOLD always.
  - HOLD→CLEAR after HOLD_CYCLES cycles in HOLD.
  - CLEAR→LOAD if the FIFO still holds an entry after the pop; otherwise CLEAR→IDLE.
- `issued_count` increments on every edge entering LOAD; 255 wraps to 0.
- Reset (asynchronous, any time, including mid-command):
  - FIFO emptied; FSM to IDLE.
  - `on`=0, `in_sel`=000, `num1`=0, `num2`=0, `out_sel`=0, `err_op`=0, `issued_count`=0, `busy`=0, `cmd_ready`=0.
  - After `rst` rises, `cmd_ready`=1 combinationally.

## Timing
- A command accepted at edge k into an empty FIFO with the FSM in IDLE:
  - LOAD outputs valid after edge k+1.
  - HOLD after edges k+2 .. k+1+HOLD_CYCLES.
  - CLEAR after the following edge.
- Each command occupies 2+HOLD_CYCLES cycles; 4 cycles at defaults.
- Back-to-back commands go CLEAR→LOAD with no IDLE gap.
- `cmd_ready` falls in the cycle after the edge that makes the FIFO full. It rises in the cycle after the pop edge.
- With the FIFO full, `cmd_valid` is ignored: no transfer and no `err_op`.
- `err_op` latency is 1 cycle from the transfer edge.

## Test plan
- Reset:
  - Drive `rst`=0 mid-HOLD, asynchronously between edges.
  - Required: all outputs immediately take their reset values.
  - After release: `cmd_ready`=1, `busy`=0, and no LOAD occurs without a new command.
- Single command:
  - Stimulus: a=0x57, b=0x1A, op=7'b1000000, accepted at edge 1.
  - Required: after edge 2, `in_sel`=010, `num1`=0x57, `num2`=0x1A, `out_sel`=0x40, `on`=1.
  - After edges 3–4: `in_sel`=100. After edge 5: `in_sel`=001.
  - After edge 6: `on`=0, `in_sel`=000, `issued_count`=1, `busy`=0.
- Full FIFO:
  - Stimulus: five commands with `cmd_valid` held high, a=0x02, b=0x04, op=7'b1000000, then a=0x03…0x06.
  - Required: four accepted on consecutive edges and `cmd_ready`=0 with the 5th pending.
  - The 5th is accepted on the edge after the first CLEAR pop.
  - LOAD phases occur exactly 4 cycles apart, with no IDLE between them.
- Illegal ops:
  - Stimulus: op=7'b0000011, then op=7'b0000000.
  - Required: two single-cycle `err_op` pulses, no LOAD, `issued_count` unchanged, FIFO empty.
- Simultaneous push/pop:
  - Stimulus: FIFO holding 2 entries, a new command accepted on the CLEAR-exit edge.
  - Required: occupancy stays 2 and the next LOAD presents the older entry.
- Wrap:
  - Stimulus: issue 256 legal commands.
  - Required: `issued_count` reads 255 after the 255th LOAD and 0 after the 256th.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - buffers ALU commands and replays each as a load/persist/reset sequence
module alu_cmd_issuer #(
  parameter int DATA_W      = 8,
  parameter int OPSEL_W     = 7,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  input  logic [OPSEL_W-1:0] cmd_op,
  output logic               on,
  output logic [2:0]         in_sel,
  output logic [DATA_W-1:0]  num1,
  output logic [DATA_W-1:0]  num2,
  output logic [OPSEL_W-1:0] out_sel,
  output logic               busy,
  output logic               err_op,
  output logic [7:0]         issued_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_CLEAR} state_t;
  state_t state, state_n;

  logic [DATA_W-1:0]  mem_a  [DEPTH];
  logic [DATA_W-1:0]  mem_b  [DEPTH];
  logic [OPSEL_W-1:0] mem_op [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr, head_idx;
  logic [AW:0]        count;
  logic [HW-1:0]      hold_cnt, hold_cnt_n;
  logic               full, xfer, op_legal, push, pop, bypass;
  logic [DATA_W-1:0]  head_a, head_b;
  logic [OPSEL_W-1:0] head_op;
  logic               on_n;
  logic [2:0]         in_sel_n;
  logic [DATA_W-1:0]  num1_n, num2_n;
  logic [OPSEL_W-1:0] out_sel_n;

  assign full      = (count == (AW+1)'(DEPTH));
  assign cmd_ready = rst && !full;
  assign op_legal  = (cmd_op != '0) && ((cmd_op & (cmd_op - OPSEL_W'(1))) == '0);
  assign xfer      = cmd_valid && cmd_ready;
  assign push      = xfer && op_legal;
  // The head is popped on the edge leaving CLEAR, so CLEAR->LOAD must look one slot ahead.
  assign pop       = (state == S_CLEAR);
  assign head_idx  = (state == S_CLEAR) ? rd_ptr + AW'(1) : rd_ptr;
  // When only the finishing entry remains, the next head is the command being pushed this edge.
  assign bypass    = (state == S_CLEAR) && (count == (AW+1)'(1));
  assign head_a    = bypass ? cmd_a  : mem_a[head_idx];
  assign head_b    = bypass ? cmd_b  : mem_b[head_idx];
  assign head_op   = bypass ? cmd_op : mem_op[head_idx];
  assign busy      = (count != '0) || (state != S_IDLE);

  // FIFO storage; emptiness is governed by the pointers, so the array needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]  <= cmd_a;
      mem_b[wr_ptr]  <= cmd_b;
      mem_op[wr_ptr] <= cmd_op;
    end
  end

  // Next state and next registered ALU control values
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    on_n       = on;
    in_sel_n   = in_sel;
    num1_n     = num1;
    num2_n     = num2;
    out_sel_n  = out_sel;
    case (state)
      S_IDLE:  if (count != '0) state_n = S_LOAD;
      S_LOAD: begin
        state_n    = S_HOLD;
        hold_cnt_n = '0;
      end
      S_HOLD: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_n = S_CLEAR;
        else hold_cnt_n = hold_cnt + HW'(1);
      end
      S_CLEAR: state_n = ((count > (AW+1)'(1)) || push) ? S_LOAD : S_IDLE;
      default: state_n = S_IDLE;
    endcase
    case (state_n)
      S_IDLE: begin
        on_n     = 1'b0;
        in_sel_n = 3'b000;
      end
      S_LOAD: begin
        on_n      = 1'b1;
        in_sel_n  = 3'b010;
        num1_n    = head_a;
        num2_n    = head_b;
        out_sel_n = head_op;
      end
      S_HOLD: begin
        on_n     = 1'b1;
        in_sel_n = 3'b100;
      end
      default: begin
        on_n     = 1'b1;
        in_sel_n = 3'b001;
      end
    endcase
  end

  // State, FIFO bookkeeping, registered outputs and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      on           <= 1'b0;
      in_sel       <= 3'b000;
      num1         <= '0;
      num2         <= '0;
      out_sel      <= '0;
      err_op       <= 1'b0;
      issued_count <= 8'd0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      on       <= on_n;
      in_sel   <= in_sel_n;
      num1     <= num1_n;
      num2     <= num2_n;
      out_sel  <= out_sel_n;
      err_op   <= xfer && !op_legal;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (state_n == S_LOAD) issued_count <= issued_count + 8'd1;
    end
  end
endmodule
